// File: rtl/mc_exec_unit_if.sv
// rtl/mc_exec_unit_if.sv - request/result bundle between a requester and mc_exec_unit
interface mc_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output start, flush, op, a, b,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, flush, op, a, b,
    output busy, done, result, flags
  );
endinterface

// File: rtl/mc_exec_unit.sv
// rtl/mc_exec_unit.sv - single-cycle ALU plus iterative shift-add multiplier
module mc_exec_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mc_exec_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_ORR  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_MULH = 3'b101;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state, state_d;
  logic [2*WIDTH-1:0] acc, acc_d;
  logic [2*WIDTH-1:0] mcand, mcand_d;
  logic [WIDTH-1:0]   mplr, mplr_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic               mulh, mulh_d;
  logic               done, done_d;
  logic [WIDTH-1:0]   result, result_d;
  logic [3:0]         flags, flags_d;
  logic               busy_c;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic               is_mul;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mul_res;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  // Single-cycle ALU; SUB carry is the inverted borrow of a + ~b + 1
  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_ORR:  alu_res = bus.a | bus.b;
      default: alu_res = '0;
    endcase
    is_mul = MUL_EN && ((bus.op == OP_MUL) || (bus.op == OP_MULH));
  end

  assign acc_step = acc + (mplr[0] ? mcand : '0);

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    mcand_d  = mcand;
    mplr_d   = mplr;
    cnt_d    = cnt;
    mulh_d   = mulh;
    result_d = result;
    flags_d  = flags;
    done_d   = 1'b0;
    busy_c   = 1'b0;
    mul_res  = mulh ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (is_mul) begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, bus.a};
            mplr_d  = bus.b;
            mulh_d  = bus.op[0];
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            result_d = alu_res;
            flags_d  = mk_flags(alu_res, alu_c, alu_v);
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        // busy drops in the final iteration so it never overlaps done
        busy_c = (cnt != LAST);
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = acc_step;
          mcand_d = mcand << 1;
          mplr_d  = mplr >> 1;
          cnt_d   = cnt + CW'(1);
          if (cnt == LAST) begin
            state_d  = S_IDLE;
            result_d = mul_res;
            flags_d  = mk_flags(mul_res, 1'b0, 1'b0);
            done_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      cnt    <= '0;
      mulh   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flags  <= 4'b0000;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      mcand  <= mcand_d;
      mplr   <= mplr_d;
      cnt    <= cnt_d;
      mulh   <= mulh_d;
      done   <= done_d;
      result <= result_d;
      flags  <= flags_d;
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done;
  assign bus.result = result;
  assign bus.flags  = flags;
endmodule

// File: tb/tb_mc_exec_unit.sv
// tb/tb_mc_exec_unit.sv - self-checking bench for mc_exec_unit at WIDTH 32 and 8
module tb_mc_exec_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_exec_unit_if #(.WIDTH(32)) ifc32 ();
  mc_exec_unit_if #(.WIDTH(8))  ifc8n ();
  mc_exec_unit_if #(.WIDTH(8))  ifc8m ();

  mc_exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (.clk(clk), .reset(reset), .bus(ifc32.slave));
  mc_exec_unit #(.WIDTH(8),  .MUL_EN(1'b0)) dut8n (.clk(clk), .reset(reset), .bus(ifc8n.slave));
  mc_exec_unit #(.WIDTH(8),  .MUL_EN(1'b1)) dut8m (.clk(clk), .reset(reset), .bus(ifc8m.slave));

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, ORR = 3'd3, MUL = 3'd4, MULH = 3'd5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          d;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic s, input logic f, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y);
    case (d)
      0: begin ifc32.start = s; ifc32.flush = f; ifc32.op = o; ifc32.a = x;      ifc32.b = y;      end
      1: begin ifc8n.start = s; ifc8n.flush = f; ifc8n.op = o; ifc8n.a = x[7:0]; ifc8n.b = y[7:0]; end
      default: begin ifc8m.start = s; ifc8m.flush = f; ifc8m.op = o; ifc8m.a = x[7:0]; ifc8m.b = y[7:0]; end
    endcase
  endtask

  function automatic logic get_done(input int d);
    case (d)
      0: return ifc32.done;
      1: return ifc8n.done;
      default: return ifc8m.done;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0: return ifc32.busy;
      1: return ifc8n.busy;
      default: return ifc8m.busy;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int d);
    case (d)
      0: return ifc32.result;
      1: return {24'd0, ifc8n.result};
      default: return {24'd0, ifc8m.result};
    endcase
  endfunction

  function automatic logic [3:0] get_flags(input int d);
    case (d)
      0: return ifc32.flags;
      1: return ifc8n.flags;
      default: return ifc8m.flags;
    endcase
  endfunction

  // Reference: plain wide arithmetic on masked operands
  function automatic void model(input int w, input bit mul_en, input logic [2:0] o,
                                input longint unsigned xi, input longint unsigned yi,
                                output longint unsigned r, output logic [3:0] fl, output int lat);
    longint unsigned mask, sign, x, y, p;
    logic c, v;
    mask = (64'd1 << w) - 64'd1;
    sign = 64'd1 << (w - 1);
    x = xi & mask;
    y = yi & mask;
    c = 1'b0;
    v = 1'b0;
    lat = 0;
    r = 0;
    case (o)
      3'd0: begin
        p = x + y;
        r = p & mask;
        c = (p >> w) != 0;
        v = ((x ^ r) & (y ^ r) & sign) != 0;
      end
      3'd1: begin
        r = (x - y) & mask;
        c = (x >= y);
        v = ((x ^ y) & (x ^ r) & sign) != 0;
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4, 3'd5: begin
        if (mul_en) begin
          p = x * y;
          r = (o == 3'd4) ? (p & mask) : ((p >> w) & mask);
          lat = w;
        end
      end
      default: r = 0;
    endcase
    fl = {(r & sign) != 0, r == 0, c, v};
  endfunction

  task automatic issue(input int d, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    drive(d, 1'b1, 1'b0, o, x, y);
    @(posedge clk);
    #1 drive(d, 1'b0, 1'b0, 3'($urandom), $urandom, $urandom);
  endtask

  // lat counts edges after the start edge; poke >= 0 pulses a start at that cycle
  task automatic wait_done(input int d, input int budget, input int poke, output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (get_done(d)) begin
        lat = k;
        break;
      end
      if (get_busy(d)) bc++;
      if (k == poke) drive(d, 1'b1, 1'b0, ADD, 32'd1, 32'd1);
      @(posedge clk);
      if (k == poke) #1 drive(d, 1'b0, 1'b0, ADD, 32'd0, 32'd0);
    end
  endtask

  task automatic count_done(input int d, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (get_done(d)) cnt++;
    end
  endtask

  task automatic run_chk(input int d, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic [3:0] ef, input int el, input string nm);
    int lat, bc;
    issue(d, o, x, y);
    wait_done(d, 100, -1, lat, bc);
    chk({nm, " latency"}, lat, el);
    chk({nm, " result"}, get_res(d), er);
    chk({nm, " flags"}, get_flags(d), ef);
    chk({nm, " busy_cycles"}, bc, (el > 0) ? el - 1 : 0);
    @(negedge clk);
    chk({nm, " done_pulse"}, get_done(d), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    int lat, bc, n;
    longint unsigned mr;
    logic [3:0] mf;
    int ml;

    reset = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, ADD, 32'd0, 32'd0);
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", ifc32.busy, 0);
    chk("reset done", ifc32.done, 0);
    chk("reset result", ifc32.result, 0);
    chk("reset flags", ifc32.flags, 0);

    // First start lands on the first edge with reset released
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, ADD, 32'd2, 32'd3);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, ADD, 32'd0, 32'd0);
    wait_done(0, 20, -1, lat, bc);
    chk("first_start latency", lat, 0);
    chk("first_start result", ifc32.result, 5);

    vecs.push_back('{0, ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 0});
    vecs.push_back('{0, SUB,  32'd5,        32'd5,        32'h00000000, 4'b0110, 0});
    vecs.push_back('{0, SUB,  32'd0,        32'd1,        32'hFFFFFFFF, 4'b1000, 0});
    vecs.push_back('{0, MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 32});
    vecs.push_back('{0, MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, 32});
    vecs.push_back('{0, AND_, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 0});
    vecs.push_back('{0, ORR,  32'h00000000, 32'h00000000, 32'h00000000, 4'b0100, 0});
    vecs.push_back('{0, 3'd6, 32'd123,      32'd456,      32'h00000000, 4'b0100, 0});
    vecs.push_back('{0, 3'd7, 32'hFFFFFFFF, 32'd1,        32'h00000000, 4'b0100, 0});
    vecs.push_back('{0, ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 0});
    vecs.push_back('{0, SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 0});
    vecs.push_back('{1, MUL,  32'h10,       32'h10,       32'h00,       4'b0100, 0});
    vecs.push_back('{1, MULH, 32'h33,       32'h22,       32'h00,       4'b0100, 0});
    vecs.push_back('{2, MUL,  32'h10,       32'h10,       32'h00,       4'b0100, 8});
    vecs.push_back('{2, MULH, 32'h10,       32'h10,       32'h01,       4'b0000, 8});
    vecs.push_back('{2, ADD,  32'h80,       32'h80,       32'h00,       4'b0111, 0});
    foreach (vecs[i])
      run_chk(vecs[i].d, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl, vecs[i].lat,
              $sformatf("vec%0d", i));

    // Back-to-back: start accepted in the done cycle
    issue(0, ADD, 32'd1, 32'd2);
    wait_done(0, 20, -1, lat, bc);
    drive(0, 1'b1, 1'b0, SUB, 32'd10, 32'd3);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, ADD, 32'd0, 32'd0);
    wait_done(0, 20, -1, lat, bc);
    chk("b2b latency", lat, 0);
    chk("b2b result", ifc32.result, 7);
    chk("b2b flags", ifc32.flags, 4'b0010);

    // Start pulsed mid-multiply is dropped
    issue(0, MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, 100, 5, lat, bc);
    chk("midbusy latency", lat, 32);
    chk("midbusy busy_cycles", bc, 31);
    chk("midbusy result", ifc32.result, 1);
    count_done(0, 6, n);
    chk("midbusy no_extra_done", n, 0);

    // Flush in the 10th multiply cycle
    run_chk(0, ADD, 32'd10, 32'd20, 32'd30, 4'b0000, 0, "pre_flush");
    issue(0, MUL, 32'd3, 32'd7);
    repeat (9) @(posedge clk);
    #1 chk("flush busy_before", ifc32.busy, 1);
    drive(0, 1'b0, 1'b1, MUL, 32'd9, 32'd9);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, ADD, 32'd0, 32'd0);
    @(negedge clk);
    chk("flush busy_after", ifc32.busy, 0);
    chk("flush result_kept", ifc32.result, 30);
    count_done(0, 40, n);
    chk("flush no_done", n, 0);
    run_chk(0, ADD, 32'd1, 32'd1, 32'd2, 4'b0000, 0, "post_flush");

    // Flush while idle does not block a start
    @(negedge clk);
    drive(0, 1'b1, 1'b1, ADD, 32'd4, 32'd4);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, ADD, 32'd0, 32'd0);
    wait_done(0, 20, -1, lat, bc);
    chk("idle_flush latency", lat, 0);
    chk("idle_flush result", ifc32.result, 8);

    // Reset in the 5th multiply cycle
    issue(0, MUL, 32'hFFFFFFFF, 32'd3);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset busy", ifc32.busy, 0);
    chk("midreset done", ifc32.done, 0);
    chk("midreset result", ifc32.result, 0);
    chk("midreset flags", ifc32.flags, 0);
    @(negedge clk);
    reset = 1'b1;
    count_done(0, 40, n);
    chk("midreset no_done", n, 0);
    run_chk(0, ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 0, "post_reset");

    // Randomized operations against the reference model
    for (int i = 0; i < 80; i++) begin
      int d;
      logic [2:0] o;
      logic [31:0] x, y;
      d = $urandom_range(0, 2);
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: x = 32'hFFFFFFFF;
        1: y = 32'h0;
        2: begin x = 32'h80000000; y = 32'h7FFFFFFF; end
        default: ;
      endcase
      if (d != 0) begin
        x = {24'd0, x[7:0]};
        y = {24'd0, y[7:0]};
      end
      model((d == 0) ? 32 : 8, d != 1, o, x, y, mr, mf, ml);
      run_chk(d, o, x, y, mr[31:0], mf, ml, $sformatf("rnd%0d d%0d op%0d a=%0h b=%0h", i, d, o, x, y));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
